// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic datapath types, widths and helpers
package arith_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  // Defaults match the multiplier: dividend holds an m+n product, divisor is n wide
  localparam int DIV_M = 16;
  localparam int DIV_N = 8;

  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/divider_step.sv
// rtl/divider_step.sv - one restoring shift-and-conditional-subtract step
module divider_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] pr,
  input  logic         dq_msb,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] pr_out,
  output logic         qbit
);

  // Compare at N+1 bits; the kept remainder is always < divisor so N bits hold it
  logic [N:0]   pr_next;
  logic [N-1:0] diff;

  assign pr_next = {pr, dq_msb};
  assign qbit    = (pr_next >= {1'b0, divisor});
  assign diff    = pr_next[N-1:0] - divisor;
  assign pr_out  = qbit ? diff : pr_next[N-1:0];

endmodule

// File: rtl/shift_subtract_binary_divider.sv
// rtl/shift_subtract_binary_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
module shift_subtract_binary_divider
  import arith_pkg::*;
#(
  parameter int M = DIV_M,
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = clog2(M);

  div_state_t    state, state_next;
  logic [N-1:0]  pr;
  logic [M-1:0]  dq;
  logic [N-1:0]  dvs;
  logic [CW-1:0] cnt;
  logic          dz;
  logic [N-1:0]  pr_step;
  logic          qbit;
  logic [M-1:0]  dq_shift;
  logic          accept;
  logic          last;

  assign accept   = start && (state != RUN);
  assign last     = (cnt == CW'(M - 1));
  assign dq_shift = {dq[M-2:0], qbit};
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  divider_step #(.N(N)) u_step (
    .pr      (pr),
    .dq_msb  (dq[M-1]),
    .divisor (dvs),
    .pr_out  (pr_step),
    .qbit    (qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A zero divisor spends a single RUN cycle so its done lands one edge after acceptance
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? RUN : IDLE;
      RUN:     if (dz || last) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pr          <= '0;
      dq          <= '0;
      dvs         <= '0;
      cnt         <= '0;
      dz          <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      pr  <= '0;
      dq  <= dividend;
      dvs <= divisor;
      cnt <= '0;
      dz  <= (divisor == '0);
    end else if (state == RUN) begin
      if (dz) begin
        quotient    <= '1;
        remainder   <= dq[N-1:0];
        div_by_zero <= 1'b1;
      end else begin
        pr  <= pr_step;
        dq  <= dq_shift;
        cnt <= cnt + 1'b1;
        // Results are published only on the final step so outputs never show partials
        if (last) begin
          quotient    <= dq_shift;
          remainder   <= pr_step;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule
